// File: rtl/muldiv_ex_if.sv
// muldiv_ex_if: execute-stage handshake between the pipeline and the
// iterative RV32M multiply/divide unit. The pipeline side is the master,
// the unit itself is the slave.
interface muldiv_ex_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  flush;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [4:0]            rd_in;
  logic                  stall;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [4:0]            rd_out;

  modport master (
    output start, flush, funct3, op_a, op_b, rd_in,
    input  stall, done, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b, rd_in,
    output stall, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_ex.sv
// muldiv_ex: iterative RV32M multiply/divide unit for the execute stage.
// Multiplies by shift-add and divides by restoring division, one bit per
// cycle over 32 cycles, holding the pipeline through a combinational stall.
// Build option: define MULDIV_DIVIDE_EN to include the divider and its
// divide-by-zero / overflow fast path; without it every divide op finishes
// one cycle after accept with a zero result.
module muldiv_ex #(
  parameter int DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  muldiv_ex_if.slave bus
);
  localparam int         W         = DATA_WIDTH;
  localparam logic [5:0] LAST_ITER = 6'(W - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [4:0]     rd_q, rd_d;
  logic           neg_q, neg_d;
  logic           done_q, done_d;
  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;

  logic           a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]   mag_a, mag_b;
  logic           accept, fast;
  logic [W-1:0]   fast_result;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] acc_step, prod;
  logic [W-1:0]   mul_res, div_res;

`ifdef MULDIV_DIVIDE_EN
  logic [W:0]     rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvsr_q, dvsr_d;
  logic [W+1:0]   div_shift, div_diff;
  logic [W:0]     rem_step;
  logic [W-1:0]   quo_step, quo_fix, rem_fix;
  logic           div_zero, div_ovf;
`endif

  // Operand decode: signedness per funct3, magnitudes and accept condition
  always_comb begin
    a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    a_neg    = a_signed & bus.op_a[W-1];
    b_neg    = b_signed & bus.op_b[W-1];
    mag_a    = a_neg ? -bus.op_a : bus.op_a;
    mag_b    = b_neg ? -bus.op_b : bus.op_b;
    accept   = (state_q == IDLE) & bus.start & ~bus.flush;
  end

  // Fast path: ops whose result is known at accept and skip CALC entirely
  always_comb begin
`ifdef MULDIV_DIVIDE_EN
    div_zero    = (bus.op_b == '0);
    div_ovf     = ~bus.funct3[0] & (bus.op_a == {1'b1, {(W-1){1'b0}}}) & (&bus.op_b);
    fast        = bus.funct3[2] & (div_zero | div_ovf);
    if (div_zero) fast_result = bus.funct3[1] ? bus.op_a : '1;
    else          fast_result = bus.funct3[1] ? '0 : bus.op_a;
`else
    fast        = bus.funct3[2];
    fast_result = '0;
`endif
  end

  // One shift-add step; on the last step this is already the full product
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : {W{1'b0}})};
    acc_step = {mul_sum, acc_q[W-1:1]};
    prod     = neg_q ? -acc_step : acc_step;
    mul_res  = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
  end

`ifdef MULDIV_DIVIDE_EN
  // One restoring-division step: shift in a dividend bit, keep the
  // difference only when it did not borrow
  always_comb begin
    div_shift = {rem_q, quo_q[W-1]};
    div_diff  = div_shift - {2'b00, dvsr_q};
    rem_step  = div_diff[W+1] ? div_shift[W:0] : div_diff[W:0];
    quo_step  = {quo_q[W-2:0], ~div_diff[W+1]};
    quo_fix   = neg_q ? -quo_step : quo_step;
    rem_fix   = neg_q ? -rem_step[W-1:0] : rem_step[W-1:0];
    div_res   = op_q[1] ? rem_fix : quo_fix;
  end
`else
  // Divide ops never enter CALC in this build
  assign div_res = '0;
`endif

  // Next-state logic: accept / fast path in IDLE, iterate and finalise in CALC
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = result_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
`ifdef MULDIV_DIVIDE_EN
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_d = bus.rd_in;
          if (fast) begin
            done_d   = 1'b1;
            result_d = fast_result;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            op_d    = bus.funct3;
            // Remainder follows the dividend; everything else the sign xor
            neg_d   = (bus.funct3[2] & bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
            mcand_d = mag_a;
            acc_d   = {{W{1'b0}}, mag_b};
`ifdef MULDIV_DIVIDE_EN
            rem_d   = '0;
            quo_d   = mag_a;
            dvsr_d  = mag_b;
`endif
          end
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_step;
`ifdef MULDIV_DIVIDE_EN
          rem_d = rem_step;
          quo_d = quo_step;
`endif
          if (cnt_q == LAST_ITER) begin
            result_d = op_q[2] ? div_res : mul_res;
            done_d   = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
`ifdef MULDIV_DIVIDE_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
`ifdef MULDIV_DIVIDE_EN
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
`endif
    end
  end

  assign bus.stall  = (accept & ~fast) | (state_q == CALC);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_ex.sv
// tb_muldiv_ex: directed bench for muldiv_ex. A cycle-level reference model
// computes results with plain integer arithmetic and tracks latency; one
// compare process checks stall/done/result every cycle, and directed
// sequences pin hand-computed results, latencies and stall counts.
// Expectations follow the build: MULDIV_DIVIDE_EN enables divide results.
module tb_muldiv_ex;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_ex_if #(.DATA_WIDTH(32)) bus ();

  muldiv_ex #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;   // expected with the divider built in
    int          lat;   // cycles from start cycle to done cycle
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIVIDE_EN
    return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
    return f[2];
`endif
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic [31:0] r;
    int          sa, sb;
    r = '0;
    if (!f[2]) begin
      ea = {{32{(f != 3'b011) && a[31]}}, a};
      eb = {{32{(f[1] == 1'b0) && b[31]}}, b};
      p  = ea * eb;
      r  = (f == 3'b000) ? p[31:0] : p[63:32];
    end
`ifdef MULDIV_DIVIDE_EN
    else if (b == 32'd0) begin
      r = f[1] ? a : 32'hFFFF_FFFF;
    end else if (!f[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = f[1] ? 32'd0 : a;
      else begin
        sa = $signed(a);
        sb = $signed(b);
        r  = f[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
    end else begin
      r = f[1] ? (a % b) : (a / b);
    end
`endif
    return r;
  endfunction

  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend = '0;
  logic [4:0]  m_rd = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_left   <= 0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_pend   <= '0;
      m_rd     <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (bus.flush) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          m_result <= m_pend;
        end else m_left <= m_left - 1;
      end else if (bus.start && !bus.flush) begin
        m_rd <= bus.rd_in;
        if (is_fast(bus.funct3, bus.op_a, bus.op_b)) begin
          m_done   <= 1'b1;
          m_result <= ref_result(bus.funct3, bus.op_a, bus.op_b);
        end else begin
          m_busy <= 1'b1;
          m_left <= 32;
          m_pend <= ref_result(bus.funct3, bus.op_a, bus.op_b);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("stall", 32'(bus.stall),
            32'(m_busy | (bus.start & ~bus.flush & ~is_fast(bus.funct3, bus.op_a, bus.op_b))));
      check("done", 32'(bus.done), 32'(m_done));
      check("result", bus.result, m_result);
      if (m_done) check("rd_out", 32'(bus.rd_out), 32'(m_rd));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic add(input string n, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res, input int lat);
    vec_t v;
    v.name = n; v.f = f; v.a = a; v.b = b; v.rd = rd; v.res = res; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic run_op(input vec_t v);
    int          cyc, stalls, lat, exp_lat;
    logic [31:0] res, exp_res;
    logic [4:0]  rdo;
`ifdef MULDIV_DIVIDE_EN
    exp_res = v.res;
    exp_lat = v.lat;
`else
    exp_res = v.f[2] ? 32'd0 : v.res;
    exp_lat = v.f[2] ? 1 : v.lat;
`endif
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = v.f; bus.op_a = v.a; bus.op_b = v.b; bus.rd_in = v.rd;
    cyc = 0; stalls = 0; lat = -1; res = '0; rdo = '0;
    while (lat < 0 && cyc < 40) begin
      @(negedge clk);
      if (bus.stall === 1'b1) stalls++;
      if (bus.done === 1'b1) begin lat = cyc; res = bus.result; rdo = bus.rd_out; end
      @(posedge clk); #1;
      cyc++;
      bus.start = (cyc < exp_lat) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    check({v.name, " result"},  res, exp_res);
    check({v.name, " latency"}, 32'(lat), 32'(exp_lat));
    check({v.name, " stalls"},  32'(stalls), (exp_lat == 1) ? 32'd0 : 32'd33);
    check({v.name, " rd_out"},  32'(rdo), 32'(v.rd));
  endtask

  task automatic watch_no_done(input int n, input string name);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;

    add("MUL 7*-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    add("MULH min*min",    3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 33);
    add("MULHU max*max",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33);
    add("MULHSU -1*2",     3'b010, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 33);
    add("MUL 2^16*2^16",   3'b000, 32'h0001_0000,  32'h0001_0000, 5'd9,  32'd0,         33);
    add("DIV 20/-6",       3'b100, 32'd20,         32'hFFFF_FFFA, 5'd10, 32'hFFFF_FFFD, 33);
    add("REM 20%-6",       3'b110, 32'd20,         32'hFFFF_FFFA, 5'd11, 32'd2,         33);
    add("DIV -20/6",       3'b100, 32'hFFFF_FFEC,  32'd6,         5'd12, 32'hFFFF_FFFD, 33);
    add("REM -20%6",       3'b110, 32'hFFFF_FFEC,  32'd6,         5'd13, 32'hFFFF_FFFE, 33);
    add("DIVU 5/0",        3'b101, 32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 1);
    add("REMU 5%0",        3'b111, 32'd5,          32'd0,         5'd15, 32'd5,         1);
    add("REM -7%0",        3'b110, 32'hFFFF_FFF9,  32'd0,         5'd16, 32'hFFFF_FFF9, 1);
    add("DIV ovf",         3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1);
    add("REM ovf",         3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'd0,         1);
    add("DIVU 100/7",      3'b101, 32'd100,        32'd7,         5'd19, 32'd14,        33);
    add("REMU 100%7",      3'b111, 32'd100,        32'd7,         5'd20, 32'd2,         33);
    add("DIV 20/5",        3'b100, 32'd20,         32'd5,         5'd21, 32'd4,         33);

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("reset stall",  32'(bus.stall),  32'd0);
    check("reset done",   32'(bus.done),   32'd0);
    check("reset result", bus.result,      32'd0);
    check("reset rd_out", 32'(bus.rd_out), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Back-to-back: second op presented in the done cycle of the first
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.rd_in = 5'd22;
    repeat (33) begin @(posedge clk); #1; end
    bus.op_a = 32'd6; bus.op_b = 32'd7; bus.rd_in = 5'd23;
    @(negedge clk);
    check("b2b first done",   32'(bus.done),   32'd1);
    check("b2b first result", bus.result,      32'd15);
    check("b2b first rd_out", 32'(bus.rd_out), 32'd22);
    repeat (33) begin @(posedge clk); #1; end
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b second done",   32'(bus.done),   32'd1);
    check("b2b second result", bus.result,      32'd42);
    check("b2b second rd_out", 32'(bus.rd_out), 32'd23);

    // Flush on the 10th CALC cycle
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'h1234; bus.op_b = 32'h10; bus.rd_in = 5'd24;
    repeat (10) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("flush stall", 32'(bus.stall), 32'd0);
    watch_no_done(40, "flush done count");
    check("flush result held", bus.result, 32'd42);
    begin
      vec_t v;
      v.name = "MUL 3*4 after flush"; v.f = 3'b000; v.a = 32'd3; v.b = 32'd4;
      v.rd = 5'd25; v.res = 32'd12; v.lat = 33;
      run_op(v);
    end

    // Flush together with start in IDLE: nothing accepted
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9; bus.rd_in = 5'd26;
    @(negedge clk);
    check("flush+start stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    watch_no_done(40, "flush+start done count");

    // Reset mid-CALC clears outputs at once and aborts the op
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd5; bus.op_b = 32'd5; bus.rd_in = 5'd27;
    repeat (15) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1; bus.start = 1'b0;
    #1;
    check("midreset stall",  32'(bus.stall),  32'd0);
    check("midreset done",   32'(bus.done),   32'd0);
    check("midreset result", bus.result,      32'd0);
    check("midreset rd_out", 32'(bus.rd_out), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    watch_no_done(40, "midreset done count");
    run_op(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
